// File: rtl/ps2_host_tx_if.sv
// Command handshake between a requester and the PS/2 host transmitter.
// The requester uses the master modport; ps2_host_tx uses the slave modport.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_error;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, tx_busy, tx_done, tx_error
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, tx_busy, tx_done, tx_error
    );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter over open-drain clk/data pull-low enables.
// Optional PS2_TX_GLITCH_FILTER_EN: 8-sample agreement filter on the synchronized lines.
//
// state     | meaning
// S_IDLE    | ready for a command, lines released
// S_INHIBIT | holding ps2_clk low before the request
// S_REQ     | start bit asserted, ps2_clk still low for one cycle
// S_SHIFT   | device clocks out D0..D7, parity, stop
// S_ACK     | waiting for the device acknowledge edge
// S_WAIT_IDLE | waiting for both lines high before reporting completion
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 6500,
    parameter int TIMEOUT_CYCLES = 975000
) (
    input  logic         clk,
    input  logic         rst,
    ps2_host_tx_if.slave tx,
    input  logic         ps2_clk_in,
    input  logic         ps2_data_in,
    output logic         ps2_clk_oe,
    output logic         ps2_data_oe
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SHIFT,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    logic [1:0] clk_sync;
    logic [1:0] data_sync;
    logic       clk_c;
    logic       data_c;
    logic       clk_prev;
    logic       fe;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk_in};
            data_sync <= {data_sync[0], ps2_data_in};
        end
    end

`ifdef PS2_TX_GLITCH_FILTER_EN
    logic [2:0] clk_flt_cnt;
    logic [2:0] data_flt_cnt;
    logic       clk_flt;
    logic       data_flt;

    // A new level is adopted only on the 8th consecutive disagreeing sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_flt_cnt  <= '0;
            data_flt_cnt <= '0;
            clk_flt      <= 1'b1;
            data_flt     <= 1'b1;
        end else begin
            if (clk_sync[1] == clk_flt) begin
                clk_flt_cnt <= '0;
            end else if (clk_flt_cnt == 3'd7) begin
                clk_flt     <= clk_sync[1];
                clk_flt_cnt <= '0;
            end else begin
                clk_flt_cnt <= clk_flt_cnt + 3'd1;
            end
            if (data_sync[1] == data_flt) begin
                data_flt_cnt <= '0;
            end else if (data_flt_cnt == 3'd7) begin
                data_flt     <= data_sync[1];
                data_flt_cnt <= '0;
            end else begin
                data_flt_cnt <= data_flt_cnt + 3'd1;
            end
        end
    end

    assign clk_c  = clk_flt;
    assign data_c = data_flt;
`else
    assign clk_c  = clk_sync[1];
    assign data_c = data_sync[1];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) clk_prev <= 1'b1;
        else      clk_prev <= clk_c;
    end

    assign fe = clk_prev & ~clk_c;

    state_t           state, state_d;
    logic [9:0]       frame, frame_d;
    logic [INH_W-1:0] inh_cnt, inh_d;
    logic [TMO_W-1:0] tmo_cnt, tmo_d;
    logic [3:0]       bitcnt, bit_d;
    logic             err_flag, err_d;
    logic             ready_q, ready_d;
    logic             clk_oe_q, clk_oe_d;
    logic             data_oe_q, data_oe_d;
    logic             done_q, done_d;
    logic             error_q, error_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            frame     <= '0;
            inh_cnt   <= '0;
            tmo_cnt   <= '0;
            bitcnt    <= '0;
            err_flag  <= 1'b0;
            ready_q   <= 1'b1;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state     <= state_d;
            frame     <= frame_d;
            inh_cnt   <= inh_d;
            tmo_cnt   <= tmo_d;
            bitcnt    <= bit_d;
            err_flag  <= err_d;
            ready_q   <= ready_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    logic       frame_timing;
    logic       line_idle;
    logic [3:0] bit_inc;

    always_comb begin
        state_d   = state;
        frame_d   = frame;
        inh_d     = inh_cnt;
        tmo_d     = tmo_cnt;
        bit_d     = bitcnt;
        err_d     = err_flag;
        ready_d   = ready_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        error_d   = 1'b0;

        line_idle    = clk_c & data_c;
        bit_inc      = (bitcnt == 4'd11) ? bitcnt : bitcnt + 4'd1;
        frame_timing = (state == S_SHIFT) || (state == S_ACK) || (state == S_WAIT_IDLE);

        case (state)
            S_IDLE: begin
                ready_d   = 1'b1;
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (tx.tx_valid && ready_q) begin
                    frame_d  = {1'b1, ~^tx.tx_data, tx.tx_data};
                    inh_d    = '0;
                    tmo_d    = '0;
                    bit_d    = '0;
                    err_d    = 1'b0;
                    ready_d  = 1'b0;
                    clk_oe_d = 1'b1;
                    state_d  = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (inh_cnt == INH_LAST) begin
                    data_oe_d = 1'b1;
                    state_d   = S_REQ;
                end else begin
                    inh_d = inh_cnt + 1'b1;
                end
            end
            S_REQ: begin
                clk_oe_d = 1'b0;
                tmo_d    = '0;
                state_d  = S_SHIFT;
            end
            S_SHIFT: begin
                tmo_d = tmo_cnt + 1'b1;
                if (fe) begin
                    // bitcnt before the edge selects the frame bit; the stop bit releases data
                    data_oe_d = ~frame[bitcnt];
                    bit_d     = bit_inc;
                    if (bitcnt == 4'd9) state_d = S_ACK;
                end
            end
            S_ACK: begin
                tmo_d = tmo_cnt + 1'b1;
                if (fe) begin
                    err_d   = data_c;
                    bit_d   = bit_inc;
                    state_d = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                tmo_d = tmo_cnt + 1'b1;
                if (line_idle) begin
                    done_d  = 1'b1;
                    error_d = err_flag;
                    ready_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d   = S_IDLE;
                ready_d   = 1'b1;
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
            end
        endcase

        // Completion on the same cycle as expiry is reported as success.
        if (frame_timing && (tmo_cnt == TMO_LAST) &&
            !((state == S_WAIT_IDLE) && line_idle)) begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            done_d    = 1'b1;
            error_d   = 1'b1;
            ready_d   = 1'b1;
            state_d   = S_IDLE;
        end
    end

    assign tx.tx_ready = ready_q;
    assign tx.tx_busy  = ~ready_q;
    assign tx.tx_done  = done_q;
    assign tx.tx_error = error_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;

endmodule
